// File: rtl/mux_tree_pipe_if.sv
// Handshake and data bundle for mux_tree_pipe: input side (data/sel/dis/valid)
// and output side (m/n/valid/ready), with views for the block and its driver.
interface mux_tree_pipe_if #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 3
);
  localparam int N = 2 ** SEL_W;

  logic [N*DATA_W-1:0] data_pad;
  logic [SEL_W-1:0]    sel_pad;
  logic                dis_pad;
  logic                in_valid_pad;
  logic                in_ready_pad;
  logic [DATA_W-1:0]   m_pad;
  logic [DATA_W-1:0]   n_pad;
  logic                out_valid_pad;
  logic                out_ready_pad;

  modport slave (
    input  data_pad, sel_pad, dis_pad, in_valid_pad, out_ready_pad,
    output in_ready_pad, m_pad, n_pad, out_valid_pad
  );

  modport master (
    output data_pad, sel_pad, dis_pad, in_valid_pad, out_ready_pad,
    input  in_ready_pad, m_pad, n_pad, out_valid_pad
  );
endinterface

// File: rtl/mux_tree_pipe.sv
// Two-stage pipelined N:1 mux with output kill and valid/ready flow control.
// Stage 1 narrows to a lo/hi pair on the low select bits; stage 2 picks by the MSB.
module mux_tree_pipe #(
  parameter int DATA_W = 1,
  parameter int SEL_W  = 3
) (
  input  logic            clk_pad,
  input  logic            rst_n_pad,
  mux_tree_pipe_if.slave  bus
);
  localparam int N = 2 ** SEL_W;

  logic [DATA_W-1:0] w_ch [N];
  logic [DATA_W-1:0] w_lo;
  logic [DATA_W-1:0] w_hi;
  logic [DATA_W-1:0] w_m_next;
  logic              w_adv1;
  logic              w_adv2;
  logic              w_take;

  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_hi;
  logic              r_msb;
  logic              r_dis;
  logic              r_v1;
  logic              r_v2;
  logic [DATA_W-1:0] r_m;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_ch
      assign w_ch[gi] = bus.data_pad[gi*DATA_W +: DATA_W];
    end

    if (SEL_W == 1) begin : g_pair
      assign w_lo = w_ch[1'b0];
      assign w_hi = w_ch[1'b1];
    end else begin : g_tree
      assign w_lo = w_ch[{1'b0, bus.sel_pad[SEL_W-2:0]}];
      assign w_hi = w_ch[{1'b1, bus.sel_pad[SEL_W-2:0]}];
    end
  endgenerate

  // A stage may move whenever the stage after it can take its contents.
  assign w_adv2 = ~r_v2 | bus.out_ready_pad;
  assign w_adv1 = ~r_v1 | w_adv2;
  assign w_take = w_adv1 & bus.in_valid_pad;

  assign w_m_next = r_dis ? '0 : (r_msb ? r_hi : r_lo);

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_v1 <= 1'b0;
    end else if (w_adv1) begin
      r_v1 <= bus.in_valid_pad;
    end
  end

  // Candidate registers carry no reset; they only load on an accepted transfer.
  always_ff @(posedge clk_pad) begin
    if (w_take) begin
      r_lo  <= w_lo;
      r_hi  <= w_hi;
      r_msb <= bus.sel_pad[SEL_W-1];
      r_dis <= bus.dis_pad;
    end
  end

  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_v2 <= 1'b0;
      r_m  <= '0;
    end else if (w_adv2) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_m <= w_m_next;
      end
    end
  end

  assign bus.in_ready_pad  = w_adv1;
  assign bus.out_valid_pad = r_v2;
  assign bus.m_pad         = r_m;
  assign bus.n_pad         = ~r_m;
endmodule

// File: tb/tb_mux_tree_pipe.sv
// Scoreboard bench: directed vectors on an 8:1 x1 instance, random valid/ready
// traffic on a 32:1 x4 instance; monitors pop expectations on each output transfer.
module tb_mux_tree_pipe;
  typedef struct {
    logic [3:0] m;
    logic [3:0] n;
    int         acc;
    bit         lat;
  } exp_t;

  int checks = 0;
  int errors = 0;

  logic clk_a = 1'b0;
  logic clk_en_a = 1'b0;
  logic rst_a = 1'b1;
  logic clk_b = 1'b0;
  logic rst_b = 1'b0;
  int   cyc_a = 0;
  bit   done_b = 1'b0;

  exp_t sb_a[$];
  exp_t sb_b[$];

  logic       hold_a = 1'b0;
  logic       hold_m_a = 1'b0;
  logic       hold_b = 1'b0;
  logic [3:0] hold_m_b = 4'h0;

  mux_tree_pipe_if #(.DATA_W(1), .SEL_W(3)) a_bus ();
  mux_tree_pipe_if #(.DATA_W(4), .SEL_W(5)) b_bus ();

  mux_tree_pipe #(.DATA_W(1), .SEL_W(3)) u_a (
    .clk_pad   (clk_a),
    .rst_n_pad (rst_a),
    .bus       (a_bus)
  );

  mux_tree_pipe #(.DATA_W(4), .SEL_W(5)) u_b (
    .clk_pad   (clk_b),
    .rst_n_pad (rst_b),
    .bus       (b_bus)
  );

  always begin
    #5;
    if (clk_en_a) clk_a = ~clk_a;
  end

  always #4 clk_b = ~clk_b;

  always @(posedge clk_a) cyc_a <= cyc_a + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_a(input logic [7:0] d, input logic [2:0] s, input logic k,
                        input logic ex, input bit lat);
    int w;
    w = 0;
    a_bus.data_pad     = d;
    a_bus.sel_pad      = s;
    a_bus.dis_pad      = k;
    a_bus.in_valid_pad = 1'b1;
    @(negedge clk_a);
    while (!a_bus.in_ready_pad && w < 200) begin
      w++;
      @(negedge clk_a);
    end
    if (w >= 200) begin
      checks++;
      errors++;
      $display("FAIL a_accept_timeout: in_ready stayed 0 for %0d cycles", w);
    end else begin
      sb_a.push_back('{m: {3'b000, ex}, n: {3'b000, ~ex}, acc: cyc_a + 1, lat: lat});
      if (lat) chk("a_no_stall", w, 0);
    end
    @(posedge clk_a);
    #1;
  endtask

  always @(negedge clk_a) begin
    if (rst_a && a_bus.out_valid_pad && a_bus.out_ready_pad) begin
      if (sb_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected: got m=%0b with empty scoreboard", a_bus.m_pad);
      end else begin
        $display("A pop: m=%0b n=%0b expected m=%0b", a_bus.m_pad, a_bus.n_pad, sb_a[0].m[0]);
        chk("a_m", a_bus.m_pad, sb_a[0].m[0]);
        chk("a_n", a_bus.n_pad, sb_a[0].n[0]);
        if (sb_a[0].lat) chk("a_latency", cyc_a + 1 - sb_a[0].acc, 2);
        sb_a.delete(0);
      end
    end
    if (rst_a && hold_a) begin
      chk("a_hold_valid", a_bus.out_valid_pad, 1);
      chk("a_hold_m", a_bus.m_pad, hold_m_a);
    end
    hold_a   <= rst_a && a_bus.out_valid_pad && !a_bus.out_ready_pad;
    hold_m_a <= a_bus.m_pad;
  end

  always @(negedge clk_b) begin
    if (rst_b && b_bus.out_valid_pad && b_bus.out_ready_pad) begin
      if (sb_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected: got m=%0h with empty scoreboard", b_bus.m_pad);
      end else begin
        $display("B pop: m=%0h n=%0h expected m=%0h", b_bus.m_pad, b_bus.n_pad, sb_b[0].m);
        chk("b_m", b_bus.m_pad, sb_b[0].m);
        chk("b_n", b_bus.n_pad, sb_b[0].n);
        sb_b.delete(0);
      end
    end
    if (rst_b && hold_b) begin
      chk("b_hold_valid", b_bus.out_valid_pad, 1);
      chk("b_hold_m", b_bus.m_pad, hold_m_b);
    end
    hold_b   <= rst_b && b_bus.out_valid_pad && !b_bus.out_ready_pad;
    hold_m_b <= b_bus.m_pad;
  end

  // Random traffic on the wide instance.
  initial begin
    int acc;
    int w;
    logic [3:0] ex;
    acc = 0;
    b_bus.data_pad      = '0;
    b_bus.sel_pad       = '0;
    b_bus.dis_pad       = 1'b0;
    b_bus.in_valid_pad  = 1'b0;
    b_bus.out_ready_pad = 1'b0;
    repeat (3) @(posedge clk_b);
    #1;
    rst_b = 1'b1;
    while (acc < 10000) begin
      b_bus.in_valid_pad = 1'($urandom_range(0, 1));
      for (int j = 0; j < 4; j++) b_bus.data_pad[j*32 +: 32] = $urandom;
      b_bus.sel_pad       = 5'($urandom_range(0, 31));
      b_bus.dis_pad       = ($urandom_range(0, 7) == 0);
      b_bus.out_ready_pad = 1'($urandom_range(0, 1));
      @(negedge clk_b);
      if (b_bus.in_valid_pad && b_bus.in_ready_pad) begin
        ex = b_bus.dis_pad ? 4'h0 : b_bus.data_pad[b_bus.sel_pad*4 +: 4];
        sb_b.push_back('{m: ex, n: ~ex, acc: 0, lat: 1'b0});
        acc++;
      end
      @(posedge clk_b);
      #1;
    end
    b_bus.in_valid_pad  = 1'b0;
    b_bus.out_ready_pad = 1'b1;
    w = 0;
    while (sb_b.size() > 0 && w < 100) begin
      @(posedge clk_b);
      w++;
    end
    #1;
    chk("b_drained", sb_b.size(), 0);
    done_b = 1'b1;
  end

  // Directed sequence on the narrow instance.
  initial begin
    int guard;
    logic [7:0] d8;
    logic [2:0] s3;
    a_bus.data_pad      = '0;
    a_bus.sel_pad       = '0;
    a_bus.dis_pad       = 1'b0;
    a_bus.in_valid_pad  = 1'b0;
    a_bus.out_ready_pad = 1'b1;

    // Reset with the clock stopped.
    #3;
    rst_a = 1'b0;
    #2;
    chk("rst_m", a_bus.m_pad, 0);
    chk("rst_n", a_bus.n_pad, 1);
    chk("rst_out_valid", a_bus.out_valid_pad, 0);
    chk("rst_in_ready", a_bus.in_ready_pad, 1);
    clk_en_a = 1'b1;
    repeat (2) @(posedge clk_a);
    #1;
    rst_a = 1'b1;
    @(posedge clk_a);
    #1;

    // Exhaustive mux, back to back with out_ready high.
    for (int d = 0; d < 256; d++) begin
      for (int s = 0; s < 8; s++) begin
        for (int k = 0; k < 2; k++) begin
          d8 = d[7:0];
          s3 = s[2:0];
          send_a(d8, s3, k[0], d8[s3] & ~k[0], 1'b1);
        end
      end
    end
    a_bus.in_valid_pad = 1'b0;
    a_bus.data_pad     = 8'h5A;
    repeat (4) @(posedge clk_a);
    #1;

    // Kill then pass.
    send_a(8'hFF, 3'd5, 1'b1, 1'b0, 1'b1);
    send_a(8'hFF, 3'd5, 1'b0, 1'b1, 1'b1);
    a_bus.in_valid_pad = 1'b0;
    repeat (4) @(posedge clk_a);
    #1;
    chk("kill_drained", sb_a.size(), 0);

    // Backpressure: A,B,C,D = 1,0,1,0.
    a_bus.out_ready_pad = 1'b0;
    fork
      begin
        send_a(8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
        send_a(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
        send_a(8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
        send_a(8'h04, 3'd1, 1'b0, 1'b0, 1'b0);
        a_bus.in_valid_pad = 1'b0;
      end
      begin
        @(posedge clk_a);
        @(posedge clk_a);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk_a);
          chk("bp_in_ready", a_bus.in_ready_pad, 0);
          chk("bp_out_valid", a_bus.out_valid_pad, 1);
          chk("bp_hold_a", a_bus.m_pad, 1);
        end
        @(posedge clk_a);
        #1;
        a_bus.out_ready_pad = 1'b1;
      end
    join
    repeat (6) @(posedge clk_a);
    #1;
    chk("bp_drained", sb_a.size(), 0);

    // Reset with two beats in flight, then a lone beat E.
    a_bus.out_ready_pad = 1'b0;
    send_a(8'h01, 3'd0, 1'b0, 1'b1, 1'b0);
    send_a(8'h02, 3'd1, 1'b0, 1'b1, 1'b0);
    a_bus.in_valid_pad = 1'b0;
    #2;
    rst_a = 1'b0;
    #1;
    chk("mid_rst_out_valid", a_bus.out_valid_pad, 0);
    chk("mid_rst_in_ready", a_bus.in_ready_pad, 1);
    chk("mid_rst_m", a_bus.m_pad, 0);
    chk("mid_rst_n", a_bus.n_pad, 1);
    sb_a.delete();
    @(posedge clk_a);
    #1;
    rst_a = 1'b1;
    a_bus.out_ready_pad = 1'b1;
    send_a(8'h80, 3'd7, 1'b0, 1'b1, 1'b1);
    a_bus.in_valid_pad = 1'b0;
    repeat (5) @(posedge clk_a);
    #1;
    chk("mid_rst_drained", sb_a.size(), 0);

    guard = 0;
    while (!done_b && guard < 200000) begin
      @(posedge clk_b);
      guard++;
    end
    if (!done_b) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: random run incomplete after %0d cycles", guard);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
